// File: rtl/mmio_initiator_pkg.sv
// Shared types and constants for the MMIO bus initiator.
//   mem_access_size_t  : access size encoding shared with the LSU
//   mmio_init_state_t  : initiator FSM states
//   EXC_*_ACCESS_FAULT : exception causes raised on a bus timeout
package cpu_modules;

    typedef enum logic [1:0] {
        BYTE        = 2'd0,
        HALF_WORD   = 2'd1,
        WORD        = 2'd2,
        DOUBLE_WORD = 2'd3
    } mem_access_size_t;

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_WAIT,
        S_RESP
    } mmio_init_state_t;

    localparam logic [4:0] EXC_LOAD_ACCESS_FAULT  = 5'd5;
    localparam logic [4:0] EXC_STORE_ACCESS_FAULT = 5'd7;

endpackage

// File: rtl/mmio_initiator_if.sv
// MMIO bus between the initiator (master) and an MMIO responder (slave).
//   addr_o/valid_o/byte_en_o/wr_o/wr_data_o : request, master -> slave
//   ready_i                                 : responder accepts the request
//   data_i/resp_valid_i                     : read data / completion
//   exc_valid_i/exc_code_i                  : responder exception
interface mmio_initiator_if;
    import cpu_modules::*;

    logic [63:0]      addr_o;
    logic             valid_o;
    mem_access_size_t byte_en_o;
    logic             wr_o;
    logic [63:0]      wr_data_o;
    logic             ready_i;
    logic [63:0]      data_i;
    logic             resp_valid_i;
    logic             exc_valid_i;
    logic [4:0]       exc_code_i;

    modport master (
        output addr_o, valid_o, byte_en_o, wr_o, wr_data_o,
        input  ready_i, data_i, resp_valid_i, exc_valid_i, exc_code_i
    );

    modport slave (
        input  addr_o, valid_o, byte_en_o, wr_o, wr_data_o,
        output ready_i, data_i, resp_valid_i, exc_valid_i, exc_code_i
    );

endinterface

// File: rtl/mmio_initiator_load_extend.sv
// Combinational size/sign extension of right-aligned load data.
//   data_i     : raw responder data
//   size_i     : access size selecting the low 8/16/32/64 bits
//   unsigned_i : zero-extend instead of sign-extend (ignored for DOUBLE_WORD)
//   data_o     : extended result
module load_extend
    import cpu_modules::*;
(
    input  logic [63:0]      data_i,
    input  mem_access_size_t size_i,
    input  logic             unsigned_i,
    output logic [63:0]      data_o
);

    always_comb begin
        data_o = data_i;
        case (size_i)
            BYTE:        data_o = {{56{~unsigned_i & data_i[7]}},  data_i[7:0]};
            HALF_WORD:   data_o = {{48{~unsigned_i & data_i[15]}}, data_i[15:0]};
            WORD:        data_o = {{32{~unsigned_i & data_i[31]}}, data_i[31:0]};
            DOUBLE_WORD: data_o = data_i;
            default:     data_o = data_i;
        endcase
    end

endmodule

// File: rtl/mmio_initiator.sv
// Bus-master end of the MMIO load/store protocol. Accepts one LSU request,
// drives it onto the MMIO bus, collects the response (or times out) and
// returns an extended load result / exception to the LSU.
//   clk, reset_n     : clock, asynchronous active-low reset
//   req_*            : LSU request channel (valid/ready)
//   bus              : MMIO bus, master side
//   rsp_*            : LSU response channel (valid/ready)
// One transaction outstanding at a time; all bus/response outputs registered.
module mmio_initiator
    import cpu_modules::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 255,
    parameter int unsigned CNT_W          = 8
) (
    input  logic                clk,
    input  logic                reset_n,

    input  logic                req_valid_i,
    output logic                req_ready_o,
    input  logic [63:0]         req_addr_i,
    input  mem_access_size_t    req_size_i,
    input  logic                req_wr_i,
    input  logic [63:0]         req_wdata_i,
    input  logic                req_unsigned_i,

    mmio_initiator_if.master    bus,

    output logic                rsp_valid_o,
    input  logic                rsp_ready_i,
    output logic [63:0]         rsp_data_o,
    output logic                rsp_exc_o,
    output logic [4:0]          rsp_exc_code_o
);

    // Timeout fires in the cycle the counter would reach TIMEOUT_CYCLES,
    // so valid_o is high for exactly TIMEOUT_CYCLES bus cycles.
    localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    mmio_init_state_t state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             valid_q, valid_d;
    logic [63:0]      addr_q, addr_d;
    mem_access_size_t size_q, size_d;
    logic             wr_q, wr_d;
    logic [63:0]      wdata_q, wdata_d;
    logic             uns_q, uns_d;
    logic             rsp_valid_q, rsp_valid_d;
    logic [63:0]      rsp_data_q, rsp_data_d;
    logic             rsp_exc_q, rsp_exc_d;
    logic [4:0]       rsp_code_q, rsp_code_d;

    logic [63:0]      ext_data;
    logic             capture;

    load_extend u_load_extend (
        .data_i     (bus.data_i),
        .size_i     (size_q),
        .unsigned_i (uns_q),
        .data_o     (ext_data)
    );

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        valid_d     = valid_q;
        addr_d      = addr_q;
        size_d      = size_q;
        wr_d        = wr_q;
        wdata_d     = wdata_q;
        uns_d       = uns_q;
        rsp_valid_d = rsp_valid_q;
        rsp_data_d  = rsp_data_q;
        rsp_exc_d   = rsp_exc_q;
        rsp_code_d  = rsp_code_q;
        capture     = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (req_valid_i) begin
                    addr_d  = req_addr_i;
                    size_d  = req_size_i;
                    wr_d    = req_wr_i;
                    wdata_d = req_wdata_i;
                    uns_d   = req_unsigned_i;
                    valid_d = 1'b1;
                    cnt_d   = '0;
                    state_d = S_REQ;
                end
            end

            S_REQ, S_WAIT: begin
                cnt_d = cnt_q + CNT_W'(1);
                // In REQ a reply only counts alongside ready_i.
                capture = (bus.exc_valid_i || bus.resp_valid_i) &&
                          (state_q == S_WAIT || bus.ready_i);
                if (capture) begin
                    valid_d     = 1'b0;
                    rsp_valid_d = 1'b1;
                    state_d     = S_RESP;
                    if (bus.exc_valid_i) begin
                        rsp_exc_d  = 1'b1;
                        rsp_code_d = bus.exc_code_i;
                        rsp_data_d = '0;
                    end else begin
                        rsp_exc_d  = 1'b0;
                        rsp_code_d = '0;
                        rsp_data_d = wr_q ? '0 : ext_data;
                    end
                end else if (cnt_q == TO_LAST) begin
                    valid_d     = 1'b0;
                    rsp_valid_d = 1'b1;
                    rsp_exc_d   = 1'b1;
                    rsp_code_d  = wr_q ? EXC_STORE_ACCESS_FAULT : EXC_LOAD_ACCESS_FAULT;
                    rsp_data_d  = '0;
                    state_d     = S_RESP;
                end else if (state_q == S_REQ && bus.ready_i) begin
                    valid_d = 1'b0;
                    state_d = S_WAIT;
                end
            end

            S_RESP: begin
                if (rsp_ready_i) begin
                    rsp_valid_d = 1'b0;
                    state_d     = S_IDLE;
                end
            end

            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            valid_q     <= 1'b0;
            addr_q      <= '0;
            size_q      <= BYTE;
            wr_q        <= 1'b0;
            wdata_q     <= '0;
            uns_q       <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= '0;
            rsp_exc_q   <= 1'b0;
            rsp_code_q  <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            valid_q     <= valid_d;
            addr_q      <= addr_d;
            size_q      <= size_d;
            wr_q        <= wr_d;
            wdata_q     <= wdata_d;
            uns_q       <= uns_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
            rsp_exc_q   <= rsp_exc_d;
            rsp_code_q  <= rsp_code_d;
        end
    end

    assign req_ready_o    = (state_q == S_IDLE);

    assign bus.addr_o     = addr_q;
    assign bus.valid_o    = valid_q;
    assign bus.byte_en_o  = size_q;
    assign bus.wr_o       = wr_q;
    assign bus.wr_data_o  = wdata_q;

    assign rsp_valid_o    = rsp_valid_q;
    assign rsp_data_o     = rsp_data_q;
    assign rsp_exc_o      = rsp_exc_q;
    assign rsp_exc_code_o = rsp_code_q;

endmodule

// File: tb/tb_mmio_initiator.sv
// Directed bench for mmio_initiator: main instance with the default watchdog,
// second instance with a 4-cycle watchdog for timeout scenarios.
module tb_mmio_initiator;
    import cpu_modules::*;

    typedef struct packed {
        logic [63:0] data;
        logic        exc;
        logic [4:0]  code;
    } exp_t;

    typedef struct packed {
        mem_access_size_t s;
        logic             u;
        logic [63:0]      din;
        logic [63:0]      dout;
    } ext_case_t;

    logic clk = 1'b0;
    logic reset_n = 1'b0;

    logic             req_valid = 1'b0, t_req_valid = 1'b0;
    logic             req_ready, t_req_ready;
    logic [63:0]      req_addr = '0;
    mem_access_size_t req_size = BYTE;
    logic             req_wr = 1'b0;
    logic [63:0]      req_wdata = '0;
    logic             req_uns = 1'b0;
    logic             rsp_ready = 1'b0;

    logic             rsp_valid, t_rsp_valid;
    logic [63:0]      rsp_data, t_rsp_data;
    logic             rsp_exc, t_rsp_exc;
    logic [4:0]       rsp_code, t_rsp_code;

    int n_cmp = 0;
    int n_bad = 0;
    exp_t sb[$];
    ext_case_t ext_tab[8];

    mmio_initiator_if bus ();
    mmio_initiator_if bus_t ();

    mmio_initiator #(.TIMEOUT_CYCLES(255), .CNT_W(8)) dut (
        .clk(clk), .reset_n(reset_n),
        .req_valid_i(req_valid), .req_ready_o(req_ready), .req_addr_i(req_addr),
        .req_size_i(req_size), .req_wr_i(req_wr), .req_wdata_i(req_wdata),
        .req_unsigned_i(req_uns), .bus(bus),
        .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready), .rsp_data_o(rsp_data),
        .rsp_exc_o(rsp_exc), .rsp_exc_code_o(rsp_code)
    );

    mmio_initiator #(.TIMEOUT_CYCLES(4), .CNT_W(3)) dut_to (
        .clk(clk), .reset_n(reset_n),
        .req_valid_i(t_req_valid), .req_ready_o(t_req_ready), .req_addr_i(req_addr),
        .req_size_i(req_size), .req_wr_i(req_wr), .req_wdata_i(req_wdata),
        .req_unsigned_i(req_uns), .bus(bus_t),
        .rsp_valid_o(t_rsp_valid), .rsp_ready_i(rsp_ready), .rsp_data_o(t_rsp_data),
        .rsp_exc_o(t_rsp_exc), .rsp_exc_code_o(t_rsp_code)
    );

    always #5 clk = ~clk;

    function automatic exp_t mk(input logic [63:0] d, input logic x, input logic [4:0] c);
        exp_t e;
        e.data = d;
        e.exc  = x;
        e.code = c;
        return e;
    endfunction

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic clear_bus();
        bus.ready_i = 1'b0; bus.resp_valid_i = 1'b0; bus.exc_valid_i = 1'b0;
        bus.data_i = '0; bus.exc_code_i = '0;
        bus_t.ready_i = 1'b0; bus_t.resp_valid_i = 1'b0; bus_t.exc_valid_i = 1'b0;
        bus_t.data_i = '0; bus_t.exc_code_i = '0;
    endtask

    task automatic issue(input string tag, input logic to_t, input logic [63:0] a,
                         input mem_access_size_t s, input logic w,
                         input logic [63:0] wd, input logic u, input exp_t e);
        req_addr = a; req_size = s; req_wr = w; req_wdata = wd; req_uns = u;
        chk({tag, "_req_ready"}, {63'd0, to_t ? t_req_ready : req_ready}, 64'd1);
        if (to_t) t_req_valid = 1'b1;
        else      req_valid   = 1'b1;
        sb.push_back(e);
        cyc();
        req_valid = 1'b0;
        t_req_valid = 1'b0;
    endtask

    task automatic check_rsp(input string tag, input logic v, input logic [63:0] d,
                             input logic x, input logic [4:0] c);
        exp_t e;
        chk({tag, "_rsp_valid"}, {63'd0, v}, 64'd1);
        chk({tag, "_sb_nonempty"}, {63'd0, sb.size() != 0}, 64'd1);
        if (sb.size() != 0) begin
            e = sb.pop_front();
            chk({tag, "_rsp_data"}, d, e.data);
            chk({tag, "_rsp_exc"}, {63'd0, x}, {63'd0, e.exc});
            chk({tag, "_rsp_code"}, {59'd0, c}, {59'd0, e.code});
        end
    endtask

    task automatic release_rsp();
        clear_bus();
        rsp_ready = 1'b1;
        cyc();
        rsp_ready = 1'b0;
    endtask

    initial begin
        ext_tab[0] = '{BYTE,        1'b0, 64'h1234_5678_9ABC_DE80, 64'hFFFF_FFFF_FFFF_FF80};
        ext_tab[1] = '{BYTE,        1'b1, 64'h1234_5678_9ABC_DE80, 64'h0000_0000_0000_0080};
        ext_tab[2] = '{HALF_WORD,   1'b0, 64'h0000_0000_0000_8001, 64'hFFFF_FFFF_FFFF_8001};
        ext_tab[3] = '{HALF_WORD,   1'b1, 64'hFFFF_FFFF_FFFF_8001, 64'h0000_0000_0000_8001};
        ext_tab[4] = '{WORD,        1'b0, 64'hDEAD_BEEF_F000_0001, 64'hFFFF_FFFF_F000_0001};
        ext_tab[5] = '{WORD,        1'b1, 64'hDEAD_BEEF_F000_0001, 64'h0000_0000_F000_0001};
        ext_tab[6] = '{WORD,        1'b0, 64'h1234_5678_7000_0001, 64'h0000_0000_7000_0001};
        ext_tab[7] = '{DOUBLE_WORD, 1'b1, 64'h8000_0000_0000_0001, 64'h8000_0000_0000_0001};

        clear_bus();
        cyc();
        cyc();
        // Reset state
        chk("rst_req_ready", {63'd0, req_ready}, 64'd1);
        chk("rst_valid", {63'd0, bus.valid_o}, 64'd0);
        chk("rst_addr", bus.addr_o, 64'd0);
        chk("rst_rsp_valid", {63'd0, rsp_valid}, 64'd0);
        chk("rst_rsp_data", rsp_data, 64'd0);
        chk("rst_rsp_exc", {63'd0, rsp_exc}, 64'd0);
        reset_n = 1'b1;
        cyc();

        // Minimum-latency DOUBLE_WORD load
        issue("t1", 1'b0, 64'h1_BFF8, DOUBLE_WORD, 1'b0, 64'd0, 1'b0,
              mk(64'h1234, 1'b0, 5'd0));
        chk("t1_valid_c1", {63'd0, bus.valid_o}, 64'd1);
        chk("t1_addr", bus.addr_o, 64'h1_BFF8);
        chk("t1_byte_en", {62'd0, bus.byte_en_o}, {62'd0, DOUBLE_WORD});
        chk("t1_wr", {63'd0, bus.wr_o}, 64'd0);
        chk("t1_rsp_valid_c1", {63'd0, rsp_valid}, 64'd0);
        bus.ready_i = 1'b1; bus.resp_valid_i = 1'b1; bus.data_i = 64'h1234;
        cyc();
        chk("t1_valid_c2", {63'd0, bus.valid_o}, 64'd0);
        check_rsp("t1", rsp_valid, rsp_data, rsp_exc, rsp_code);
        release_rsp();
        chk("t1_idle_rsp_valid", {63'd0, rsp_valid}, 64'd0);
        chk("t1_idle_req_ready", {63'd0, req_ready}, 64'd1);

        // Size/sign extension table
        for (int i = 0; i < 8; i++) begin
            issue("ext", 1'b0, 64'h1_0000 + 64'(i), ext_tab[i].s, 1'b0, 64'd0, ext_tab[i].u,
                  mk(ext_tab[i].dout, 1'b0, 5'd0));
            bus.ready_i = 1'b1; bus.resp_valid_i = 1'b1; bus.data_i = ext_tab[i].din;
            cyc();
            check_rsp($sformatf("ext%0d", i), rsp_valid, rsp_data, rsp_exc, rsp_code);
            release_rsp();
        end

        // Store WORD answered by an exception (resp_valid also high: exception wins)
        issue("t3", 1'b0, 64'h1_4000, WORD, 1'b1, 64'hCAFE_BABE, 1'b0, mk(64'd0, 1'b1, 5'd7));
        chk("t3_wr", {63'd0, bus.wr_o}, 64'd1);
        chk("t3_wr_data", bus.wr_data_o, 64'hCAFE_BABE);
        chk("t3_byte_en", {62'd0, bus.byte_en_o}, {62'd0, WORD});
        bus.ready_i = 1'b1; bus.exc_valid_i = 1'b1; bus.exc_code_i = 5'd7;
        bus.resp_valid_i = 1'b1; bus.data_i = 64'hFFFF;
        cyc();
        chk("t3_valid_c2", {63'd0, bus.valid_o}, 64'd0);
        check_rsp("t3", rsp_valid, rsp_data, rsp_exc, rsp_code);
        release_rsp();
        chk("t3_valid_after", {63'd0, bus.valid_o}, 64'd0);

        // Stall in REQ, then WAIT for two cycles, then completion
        issue("t4", 1'b0, 64'h2000, DOUBLE_WORD, 1'b1, 64'h0123_4567_89AB_CDEF, 1'b0,
              mk(64'd0, 1'b0, 5'd0));
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("t4_valid_%0d", i), {63'd0, bus.valid_o}, 64'd1);
            chk($sformatf("t4_addr_%0d", i), bus.addr_o, 64'h2000);
            chk($sformatf("t4_wdata_%0d", i), bus.wr_data_o, 64'h0123_4567_89AB_CDEF);
            if (i < 3) cyc();
        end
        bus.ready_i = 1'b1;
        cyc();
        bus.ready_i = 1'b0;
        chk("t4_wait_valid", {63'd0, bus.valid_o}, 64'd0);
        chk("t4_wait_rsp0", {63'd0, rsp_valid}, 64'd0);
        cyc();
        chk("t4_wait_rsp1", {63'd0, rsp_valid}, 64'd0);
        bus.resp_valid_i = 1'b1; bus.data_i = 64'h5A5A;
        cyc();
        check_rsp("t4", rsp_valid, rsp_data, rsp_exc, rsp_code);
        release_rsp();
        chk("t4_single_rsp", {63'd0, rsp_valid}, 64'd0);

        // Watchdog instance: load never answered
        issue("to_ld", 1'b1, 64'h1_0000, DOUBLE_WORD, 1'b0, 64'd0, 1'b0,
              mk(64'd0, 1'b1, EXC_LOAD_ACCESS_FAULT));
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("to_valid_%0d", i), {63'd0, bus_t.valid_o}, 64'd1);
            chk($sformatf("to_norsp_%0d", i), {63'd0, t_rsp_valid}, 64'd0);
            cyc();
        end
        chk("to_valid_drop", {63'd0, bus_t.valid_o}, 64'd0);
        check_rsp("to_ld", t_rsp_valid, t_rsp_data, t_rsp_exc, t_rsp_code);
        bus_t.ready_i = 1'b1; bus_t.resp_valid_i = 1'b1; bus_t.data_i = 64'hFFFF;
        cyc();
        chk("to_late_exc", {63'd0, t_rsp_exc}, 64'd1);
        chk("to_late_code", {59'd0, t_rsp_code}, {59'd0, EXC_LOAD_ACCESS_FAULT});
        chk("to_late_data", t_rsp_data, 64'd0);
        rsp_ready = 1'b1;
        cyc();
        rsp_ready = 1'b0;
        chk("to_late_idle0", {63'd0, t_rsp_valid}, 64'd0);
        cyc();
        chk("to_late_idle1", {63'd0, t_rsp_valid}, 64'd0);
        chk("to_late_req_ready", {63'd0, t_req_ready}, 64'd1);
        clear_bus();

        // Watchdog on a store -> store access fault
        issue("to_st", 1'b1, 64'h1_0008, WORD, 1'b1, 64'h77, 1'b0,
              mk(64'd0, 1'b1, EXC_STORE_ACCESS_FAULT));
        repeat (4) cyc();
        check_rsp("to_st", t_rsp_valid, t_rsp_data, t_rsp_exc, t_rsp_code);
        release_rsp();

        // Reply in the final watchdog cycle beats the timeout
        issue("to_edge", 1'b1, 64'h1_0010, BYTE, 1'b0, 64'd0, 1'b1, mk(64'h55, 1'b0, 5'd0));
        repeat (3) cyc();
        chk("to_edge_pending", {63'd0, t_rsp_valid}, 64'd0);
        bus_t.ready_i = 1'b1; bus_t.resp_valid_i = 1'b1; bus_t.data_i = 64'hAA55;
        cyc();
        check_rsp("to_edge", t_rsp_valid, t_rsp_data, t_rsp_exc, t_rsp_code);
        release_rsp();

        // Response back-pressure, no bypass, then reset in REQ
        issue("t6", 1'b0, 64'h3000, WORD, 1'b0, 64'd0, 1'b0,
              mk(64'hFFFF_FFFF_89AB_CDEF, 1'b0, 5'd0));
        bus.ready_i = 1'b1; bus.resp_valid_i = 1'b1; bus.data_i = 64'h0000_0000_89AB_CDEF;
        cyc();
        check_rsp("t6", rsp_valid, rsp_data, rsp_exc, rsp_code);
        clear_bus();
        req_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            cyc();
            chk($sformatf("t6_hold_valid_%0d", i), {63'd0, rsp_valid}, 64'd1);
            chk($sformatf("t6_hold_data_%0d", i), rsp_data, 64'hFFFF_FFFF_89AB_CDEF);
            chk($sformatf("t6_hold_req_ready_%0d", i), {63'd0, req_ready}, 64'd0);
            chk($sformatf("t6_hold_busvalid_%0d", i), {63'd0, bus.valid_o}, 64'd0);
        end
        rsp_ready = 1'b1;
        cyc();
        rsp_ready = 1'b0;
        chk("t6_nobypass_valid", {63'd0, bus.valid_o}, 64'd0);
        chk("t6_nobypass_ready", {63'd0, req_ready}, 64'd1);
        sb.push_back(mk(64'd0, 1'b0, 5'd0));
        cyc();
        req_valid = 1'b0;
        chk("t6_accept_valid", {63'd0, bus.valid_o}, 64'd1);
        #2;
        reset_n = 1'b0;
        #1;
        chk("t6_rst_valid", {63'd0, bus.valid_o}, 64'd0);
        chk("t6_rst_rsp_valid", {63'd0, rsp_valid}, 64'd0);
        chk("t6_rst_req_ready", {63'd0, req_ready}, 64'd1);
        void'(sb.pop_back());
        cyc();
        reset_n = 1'b1;
        cyc();
        chk("end_sb_empty", 64'(sb.size()), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
